// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
// Module      : encoder
// Description : Registered LSB-priority encoder. Reduces a request vector of
//               2**logS bits to the binary index of its lowest set bit, with
//               valid, all-zero and (optionally) multi-hot error flags.
//               Optional feature macro: ENCODER_ONEHOT_CHECK_EN enables the
//               multi-hot (popcount >= 2) error flag; otherwise err_o is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder #(
  parameter int logS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [2**logS-1:0] in_i,
  output logic [logS-1:0]   out_o,
  output logic              out_valid_o,
  output logic              zero_o,
  output logic              err_o
);

  localparam int c_WIDTH = 2**logS;

  logic [logS-1:0] w_idx;
  logic            w_any;

  logic [logS-1:0] out_d,       out_q;
  logic            out_valid_d, out_valid_q;
  logic            zero_d,      zero_q;

  // Priority encode: scan from the top down so the lowest set bit is the
  // last assignment and therefore wins.
  always_comb begin
    w_idx = '0;
    for (int i = c_WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        w_idx = logS'(i);
      end
    end
  end

  assign w_any = |in_i;

  // Next-state for index/valid/zero; idle cycles hold index and zero flag.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    if (in_valid_i) begin
      out_d       = w_any ? w_idx : '0;
      out_valid_d = w_any;
      zero_d      = ~w_any;
    end
  end

  // Result registers; reset wins over any accepted input in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic w_multi;
  logic err_d, err_q;

  // Clearing the lowest set bit leaves something behind only when two or
  // more bits were set, which avoids a full popcount.
  always_comb begin
    w_multi = |(in_i & (in_i - c_WIDTH'(1)));
    err_d   = in_valid_i & w_multi;
  end

  // Multi-hot error flag register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign zero_o      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder
// Description : Self-checking bench for encoder (logS=4). A reference model
//               pushes expected outputs into a queue as each input is driven;
//               each scenario task pops and compares after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder;

  localparam int LOGS = 4;
  localparam int N    = 2**LOGS;
`ifdef ENCODER_ONEHOT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [LOGS-1:0] out;
    logic            ov;
    logic            zero;
    logic            err;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [N-1:0]    in_v;
  logic [LOGS-1:0] out_v;
  logic            out_valid;
  logic            zero;
  logic            err;

  exp_t sb[$];
  logic [LOGS-1:0] m_out;
  logic            m_zero;
  int n_cmp  = 0;
  int n_fail = 0;

  encoder #(.logS(LOGS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_i        (in_v),
    .out_o       (out_v),
    .out_valid_o (out_valid),
    .zero_o      (zero),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and push the model's expected result.
  task automatic apply(input logic rn, input logic v, input logic [N-1:0] d);
    exp_t e;
    int   idx;
    bit   found;
    rst_n    = rn;
    in_valid = v;
    in_v     = d;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && d[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    if (!rn) begin
      m_out  = '0;
      m_zero = 1'b0;
      e      = '0;
    end else if (v) begin
      m_out  = found ? LOGS'(idx) : '0;
      m_zero = !found;
      e.out  = m_out;
      e.ov   = found;
      e.zero = m_zero;
      e.err  = ERR_EN && ($countones(d) >= 2);
    end else begin
      e.out  = m_out;
      e.ov   = 1'b0;
      e.zero = m_zero;
      e.err  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e, g;
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b1, 16'hFFFF);
      @(posedge clk); #1;
      g = {out_v, out_valid, zero, err};
      e = sb.pop_front();
      n_cmp++;
      if (g !== e || g !== exp_t'(0)) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", k, g, e);
      end
    end
  endtask

  task automatic test_walk();
    exp_t e, g;
    for (int i = 0; i < N; i++) begin
      apply(1'b1, 1'b1, N'(1) << i);
      @(posedge clk); #1;
      g = {out_v, out_valid, zero, err};
      e = sb.pop_front();
      n_cmp++;
      if (g !== e || out_v !== LOGS'(i) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL walk[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e, g;
    apply(1'b1, 1'b1, 16'h0000);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || out_v !== 4'd0 || out_valid !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_input: got %h expected %h", g, e);
    end
  endtask

  task automatic test_multi();
    exp_t e, g;
    logic [N-1:0] pats [3];
    logic [LOGS-1:0] idxs [3];
    pats[0] = 16'h0028; idxs[0] = 4'd3;
    pats[1] = 16'h8001; idxs[1] = 4'd0;
    pats[2] = 16'hFFFF; idxs[2] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, pats[k]);
      @(posedge clk); #1;
      g = {out_v, out_valid, zero, err};
      e = sb.pop_front();
      n_cmp++;
      if (g !== e || out_v !== idxs[k] || err !== ERR_EN) begin
        n_fail++;
        $display("FAIL multi[%h]: got %h expected %h", pats[k], g, e);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e, g;
    apply(1'b1, 1'b1, 16'h0100);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || out_v !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_load: got %h expected %h", g, e);
    end
    apply(1'b1, 1'b0, 16'h0002);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || out_v !== 4'd8 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: got %h expected %h", g, e);
    end
  endtask

  task automatic test_reset_inflight();
    exp_t e, g;
    apply(1'b1, 1'b1, 16'h0400);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || out_v !== 4'd10) begin
      n_fail++;
      $display("FAIL inflight_load: got %h expected %h", g, e);
    end
    apply(1'b0, 1'b1, 16'h0400);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || g !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL inflight_reset: got %h expected %h", g, e);
    end
    apply(1'b1, 1'b0, 16'h0400);
    @(posedge clk); #1;
    g = {out_v, out_valid, zero, err};
    e = sb.pop_front();
    n_cmp++;
    if (g !== e || out_v === 4'd10) begin
      n_fail++;
      $display("FAIL inflight_after: got %h expected %h", g, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    logic [N-1:0] d;
    logic v;
    for (int k = 0; k < 60; k++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: d = N'(1) << $urandom_range(0, N - 1);
        1: d = '0;
        default: d = N'($urandom);
      endcase
      apply(1'b1, v, d);
      @(posedge clk); #1;
      g = {out_v, out_valid, zero, err};
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] in=%h v=%b: got %h expected %h", k, d, v, g, e);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_v     = '0;
    m_out    = '0;
    m_zero   = 1'b0;
    #1;
    test_reset();
    test_walk();
    test_zero();
    test_multi();
    test_hold();
    test_reset_inflight();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 Parameter logS, default 4: output index width; input width is 2**logS (default 16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  qualifies in for the current cycle.
REQ-005 in  input  2**logS  request vector, normally one-hot, bit i = requester i.
REQ-006 out  output  logS  registered binary index of selected bit.
REQ-007 out_valid  output  1  registered; out holds a result for a valid, non-zero input.
REQ-008 zero  output  1  registered; last accepted input had no bit set.
REQ-009 err  output  1  registered; last accepted input had more than one bit set (see Configuration).

Function
REQ-010 Selection: out = index of the lowest-numbered set bit of in (priority encoder, LSB wins); for one-hot input this equals the plain one-hot-to-binary value.
REQ-011 Latency exactly 1 cycle: values sampled at edge k appear on outputs after edge k; no bubbles; throughput one input per cycle.
REQ-012 in_valid=1, in non-zero: out <= index, out_valid <= 1, zero <= 0.
REQ-013 in_valid=1, in all zero: out <= 0, out_valid <= 0, zero <= 1.
REQ-014 in_valid=0: out and zero hold previous value; out_valid <= 0; err <= 0.
REQ-015 Highest bit 2**logS-1 alone set -> out = all ones (2**logS-1); no wrap or truncation.
REQ-016 Bit 0 set together with any other bits -> out = 0.
REQ-017 logS=1 supported: 2-bit input, 1-bit out.
REQ-018 Combinational logic between in and registers only; no combinational in-to-out path.
REQ-019 No X propagation: all outputs driven to defined values at all times after the first reset edge.

Reset
REQ-020 On rising clk with rst_n=0: out=0, out_valid=0, zero=0, err=0; inputs ignored that cycle.
REQ-021 Reset takes priority over in_valid in the same cycle; a result in flight is discarded.
REQ-022 First input accepted on the first edge with rst_n=1; its result is visible after that edge.

Configuration
REQ-023 Macro ENCODER_ONEHOT_CHECK_EN defined: err <= 1 when in_valid=1 and popcount(in) >= 2, else 0; out still follows REQ-010; out_valid unaffected.
REQ-024 Macro undefined: no popcount/check logic synthesized; err tied constant 0.

Verification (logS=4)
REQ-025 rst_n=0 for 2 cycles with in=16'hFFFF, in_valid=1 -> all outputs 0 throughout.
REQ-026 Walk one-hot 16'h0001..16'h8000, in_valid=1 every cycle -> out=0..15 one cycle later each, out_valid=1, zero=0, err=0.
REQ-027 in=16'h0000, in_valid=1 -> out=0, out_valid=0, zero=1 next cycle.
REQ-028 in=16'h0028 (bits 3,5), in_valid=1 -> out=3, out_valid=1; err=1 with ENCODER_ONEHOT_CHECK_EN, err=0 without.
REQ-029 in=16'h0100 accepted, then in_valid=0 with in=16'h0002 -> out stays 8, out_valid drops to 0.
REQ-030 in=16'h0400 accepted, rst_n=0 next cycle -> out=0, out_valid=0 after that edge; result 10 never reappears.
